// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single main-memory line port between the icache refill path and
// the dcache miss/writeback path. Round-robin between the two requesters, one
// transaction in flight at a time, every output registered, and a watchdog
// that abandons a transaction memory never completes.
//
// Transaction shape: IDLE (arbitrate) -> BUSY (strobe held until m_ready_i or
// watchdog) -> DONE (one-cycle ready/timeout pulse to the owner) -> IDLE.

module mem_port_arbiter #(
  parameter int ADDRESS_SIZE   = 40,
  parameter int MEM_BUS        = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    ic_strobe_i,
  input  logic [ADDRESS_SIZE-1:0] ic_addr_i,
  output logic [MEM_BUS-1:0]      ic_rdata_o,
  output logic                    ic_ready_o,

  input  logic                    dc_strobe_i,
  input  logic                    dc_we_i,
  input  logic [ADDRESS_SIZE-1:0] dc_addr_i,
  input  logic [MEM_BUS-1:0]      dc_wdata_i,
  output logic [MEM_BUS-1:0]      dc_rdata_o,
  output logic                    dc_ready_o,

  output logic [ADDRESS_SIZE-1:0] m_a_o,
  output logic                    m_strobe_o,
  output logic                    m_we_o,
  output logic [MEM_BUS-1:0]      m_wdata_o,
  input  logic [MEM_BUS-1:0]      m_rdata_i,
  input  logic                    m_ready_i,

  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  // A zero TIMEOUT_CYCLES disables the watchdog; keep the counter at least
  // one bit wide so the declarations stay legal in that case.
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_t;

  // Registered state and outputs (_q) with their next values (_d).
  state_t                  state_q, state_d;
  owner_t                  last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    wdog_fire;
  logic                    pick_dc;

  logic [1:0]              grant_q, grant_d;
  logic [ADDRESS_SIZE-1:0] m_a_q, m_a_d;
  logic                    m_strobe_q, m_strobe_d;
  logic                    m_we_q, m_we_d;
  logic [MEM_BUS-1:0]      m_wdata_q, m_wdata_d;
  logic [MEM_BUS-1:0]      ic_rdata_q, ic_rdata_d;
  logic [MEM_BUS-1:0]      dc_rdata_q, dc_rdata_d;
  logic                    ic_ready_q, ic_ready_d;
  logic                    dc_ready_q, dc_ready_d;
  logic                    timeout_q, timeout_d;

  // The counter holds the number of BUSY cycles already spent; the watchdog
  // fires in the BUSY cycle that would bring it up to TIMEOUT_CYCLES.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign wdog_fire = WDOG_EN && (cnt_inc == CNT_LIMIT);

  // State register plus every registered output; reset returns to IDLE with
  // the round-robin pointer on the dcache so the icache wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_q     <= OWNER_DC;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      m_a_q      <= '0;
      m_strobe_q <= 1'b0;
      m_we_q     <= 1'b0;
      m_wdata_q  <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      m_a_q      <= m_a_d;
      m_strobe_q <= m_strobe_d;
      m_we_q     <= m_we_d;
      m_wdata_q  <= m_wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_ready_q <= ic_ready_d;
      dc_ready_q <= dc_ready_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and next-output logic: everything holds by default except the
  // one-cycle pulses, which default low.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    m_a_d      = m_a_q;
    m_strobe_d = m_strobe_q;
    m_we_d     = m_we_q;
    m_wdata_d  = m_wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_ready_d = 1'b0;
    dc_ready_d = 1'b0;
    timeout_d  = 1'b0;
    pick_dc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ic_strobe_i || dc_strobe_i) begin
          // dcache wins when it is alone, or on a tie when icache went last.
          pick_dc    = dc_strobe_i && (!ic_strobe_i || (last_q == OWNER_IC));
          state_d    = BUSY;
          m_strobe_d = 1'b1;
          if (pick_dc) begin
            grant_d   = 2'b10;
            m_a_d     = dc_addr_i;
            m_we_d    = dc_we_i;
            m_wdata_d = dc_wdata_i;
          end else begin
            grant_d   = 2'b01;
            m_a_d     = ic_addr_i;
            m_we_d    = 1'b0;
            m_wdata_d = '0;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_inc;
        // A completion in the same cycle as the watchdog limit takes priority.
        if (m_ready_i || wdog_fire) begin
          state_d    = DONE;
          m_strobe_d = 1'b0;
          timeout_d  = !m_ready_i;
          if (grant_q[1]) begin
            last_d     = OWNER_DC;
            dc_ready_d = 1'b1;
            dc_rdata_d = m_ready_i ? m_rdata_i : '0;
          end else begin
            last_d     = OWNER_IC;
            ic_ready_d = 1'b1;
            ic_rdata_d = m_ready_i ? m_rdata_i : '0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end

      default: begin
        state_d    = IDLE;
        grant_d    = 2'b00;
        m_strobe_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  assign ic_rdata_o = ic_rdata_q;
  assign ic_ready_o = ic_ready_q;
  assign dc_rdata_o = dc_rdata_q;
  assign dc_ready_o = dc_ready_q;
  assign m_a_o      = m_a_q;
  assign m_strobe_o = m_strobe_q;
  assign m_we_o     = m_we_q;
  assign m_wdata_o  = m_wdata_q;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed plus randomized bench for mem_port_arbiter. The bench plays the
// memory and both caches; a transaction-level model (owner choice, busy
// length, timeout outcome, returned line) supplies every expected value.

module tb_mem_port_arbiter;

  localparam int AW = 40;
  localparam int DW = 128;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_strobe;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          ic_ready;
  logic          dc_strobe;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [DW-1:0] dc_rdata;
  logic          dc_ready;
  logic [AW-1:0] m_a;
  logic          m_strobe;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic [1:0]    grant;
  logic          timeout;

  int testsRun    = 0;
  int testsFailed = 0;

  // Transaction-level model state.
  bit            modelLastDc;
  logic [DW-1:0] icRdExp;
  logic [DW-1:0] dcRdExp;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDRESS_SIZE  (AW),
    .MEM_BUS       (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ic_strobe_i(ic_strobe),
    .ic_addr_i  (ic_addr),
    .ic_rdata_o (ic_rdata),
    .ic_ready_o (ic_ready),
    .dc_strobe_i(dc_strobe),
    .dc_we_i    (dc_we),
    .dc_addr_i  (dc_addr),
    .dc_wdata_i (dc_wdata),
    .dc_rdata_o (dc_rdata),
    .dc_ready_o (dc_ready),
    .m_a_o      (m_a),
    .m_strobe_o (m_strobe),
    .m_we_o     (m_we),
    .m_wdata_o  (m_wdata),
    .m_rdata_i  (m_rdata),
    .m_ready_i  (m_ready),
    .grant_o    (grant),
    .timeout_o  (timeout)
  );

  // Safety net so the run always ends even if the clock loop misbehaves.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] aborted");
  end

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] randAddr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[AW-1:0];
  endfunction

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit icS, input bit dcS, input bit we,
                               input logic [AW-1:0] icA, input logic [AW-1:0] dcA,
                               input logic [DW-1:0] wd);
    ic_strobe = icS;
    dc_strobe = dcS;
    dc_we     = we;
    ic_addr   = icA;
    dc_addr   = dcA;
    dc_wdata  = wd;
  endtask

  task automatic modelReset();
    modelLastDc = 1'b1;
    icRdExp     = '0;
    dcRdExp     = '0;
  endtask

  // One complete transaction, starting with the strobes already presented.
  // lat = BUSY cycles memory waits before m_ready_i; lat >= TO never answers.
  task automatic runTxn(input int lat, input logic [DW-1:0] rd, input bit keepStrobe,
                        input bit dropEarly, input string tag);
    bit            ownDc;
    bit            expTo;
    bit            expWe;
    int            busy;
    logic [1:0]    expGrant;
    logic [AW-1:0] expA;
    logic [DW-1:0] expWd;

    ownDc    = dc_strobe && (!ic_strobe || !modelLastDc);
    expGrant = ownDc ? 2'b10 : 2'b01;
    expA     = ownDc ? dc_addr : ic_addr;
    expWe    = ownDc ? dc_we : 1'b0;
    expWd    = ownDc ? dc_wdata : '0;
    expTo    = (lat >= TO);
    busy     = expTo ? TO : lat + 1;

    step();
    checkOutput({tag, "_strobe_up"}, DW'(m_strobe), DW'(1'b1));
    checkOutput({tag, "_grant"}, DW'(grant), DW'(expGrant));
    checkOutput({tag, "_addr"}, DW'(m_a), DW'(expA));
    checkOutput({tag, "_we"}, DW'(m_we), DW'(expWe));
    checkOutput({tag, "_wdata"}, m_wdata, expWd);

    if (dropEarly) begin
      if (ownDc) dc_strobe = 1'b0;
      else       ic_strobe = 1'b0;
    end

    for (int j = 1; j <= busy; j++) begin
      if (!expTo && (j == lat + 1)) begin
        m_ready = 1'b1;
        m_rdata = rd;
      end else begin
        m_ready = 1'b0;
        m_rdata = rand128();
      end
      if (j > 1) begin
        checkOutput({tag, "_busy_strobe"}, DW'(m_strobe), DW'(1'b1));
        checkOutput({tag, "_busy_addr"}, DW'(m_a), DW'(expA));
        checkOutput({tag, "_busy_ready"}, DW'({ic_ready, dc_ready, timeout}), DW'(3'b000));
      end
      step();
    end

    // DONE cycle: memory answering here must be ignored.
    m_ready = 1'b1;
    m_rdata = rand128();
    if (ownDc) dcRdExp = expTo ? '0 : rd;
    else       icRdExp = expTo ? '0 : rd;
    modelLastDc = ownDc;

    checkOutput({tag, "_ic_ready"}, DW'(ic_ready), DW'(!ownDc));
    checkOutput({tag, "_dc_ready"}, DW'(dc_ready), DW'(ownDc));
    checkOutput({tag, "_timeout"}, DW'(timeout), DW'(expTo));
    checkOutput({tag, "_strobe_down"}, DW'(m_strobe), DW'(1'b0));
    checkOutput({tag, "_grant_held"}, DW'(grant), DW'(expGrant));
    checkOutput({tag, "_ic_rdata"}, ic_rdata, icRdExp);
    checkOutput({tag, "_dc_rdata"}, dc_rdata, dcRdExp);

    if (!keepStrobe) begin
      if (ownDc) dc_strobe = 1'b0;
      else       ic_strobe = 1'b0;
    end

    step();
    m_ready = 1'b0;
    checkOutput({tag, "_idle_pulses"}, DW'({ic_ready, dc_ready, timeout}), DW'(3'b000));
    checkOutput({tag, "_idle_grant"}, DW'(grant), DW'(2'b00));
    checkOutput({tag, "_idle_ic_rdata"}, ic_rdata, icRdExp);
    checkOutput({tag, "_idle_dc_rdata"}, dc_rdata, dcRdExp);
  endtask

  initial begin
    logic [DW-1:0] junk;

    // Reset state.
    rst     = 1'b1;
    m_ready = 1'b0;
    m_rdata = '0;
    applyStimulus(0, 0, 0, '0, '0, '0);
    modelReset();
    step();
    checkOutput("reset_strobe", DW'(m_strobe), DW'(1'b0));
    checkOutput("reset_grant", DW'(grant), DW'(2'b00));
    checkOutput("reset_pulses", DW'({ic_ready, dc_ready, timeout}), DW'(3'b000));
    checkOutput("reset_ic_rdata", ic_rdata, '0);
    checkOutput("reset_dc_rdata", dc_rdata, '0);
    step();
    rst = 1'b0;
    step();

    // icache read, memory answers two cycles after the strobe.
    applyStimulus(1, 0, 0, 40'h10_0000_0040, '0, '0);
    runTxn(2, {16{8'hA5}}, 0, 0, "t1_ic_read");

    // dcache write.
    applyStimulus(0, 1, 1, '0, 40'h80, 128'h1234);
    runTxn(0, rand128(), 0, 0, "t2_dc_write");

    // Memory pulsing ready while idle changes nothing.
    junk    = rand128();
    m_ready = 1'b1;
    m_rdata = junk;
    step();
    m_ready = 1'b0;
    step();
    checkOutput("idle_mready_strobe", DW'(m_strobe), DW'(1'b0));
    checkOutput("idle_mready_pulses", DW'({ic_ready, dc_ready, timeout}), DW'(3'b000));
    checkOutput("idle_mready_ic_rdata", ic_rdata, icRdExp);
    checkOutput("idle_mready_dc_rdata", dc_rdata, dcRdExp);

    // Tie from reset: icache first, then the pending dcache.
    rst = 1'b1;
    step();
    rst = 1'b0;
    modelReset();
    applyStimulus(1, 1, 0, 40'h00_0000_1000, 40'h00_0000_2000, rand128());
    runTxn(1, rand128(), 0, 0, "t3_tie_first");
    runTxn(0, rand128(), 0, 0, "t3_tie_second");

    // Both held continuously: grants alternate.
    applyStimulus(1, 1, 1, 40'h00_0000_3000, 40'h00_0000_4000, rand128());
    runTxn(0, rand128(), 1, 0, "t3_alt1");
    runTxn(0, rand128(), 1, 0, "t3_alt2");
    runTxn(1, rand128(), 1, 0, "t3_alt3");
    runTxn(0, rand128(), 0, 0, "t3_alt4");
    runTxn(0, rand128(), 0, 0, "t3_alt5");

    // Owner dropping its strobe mid-transaction is ignored.
    applyStimulus(1, 0, 0, 40'h00_0000_5000, '0, '0);
    runTxn(1, rand128(), 0, 1, "drop_early");

    // Watchdog: no answer, then an answer exactly on the limit cycle.
    applyStimulus(0, 1, 0, '0, 40'h00_0000_6000, '0);
    runTxn(TO, rand128(), 0, 0, "t4_timeout");
    applyStimulus(1, 0, 0, 40'h00_0000_7000, '0, '0);
    runTxn(TO - 1, rand128(), 0, 0, "t4_limit_ready");

    // Reset in the middle of a dcache transaction.
    applyStimulus(1, 1, 0, 40'h00_0000_8000, 40'h00_0000_9000, '0);
    step();
    checkOutput("t5_grant_before_rst", DW'(grant), DW'(2'b10));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    modelReset();
    checkOutput("t5_rst_strobe", DW'(m_strobe), DW'(1'b0));
    checkOutput("t5_rst_grant", DW'(grant), DW'(2'b00));
    checkOutput("t5_rst_pulses", DW'({ic_ready, dc_ready, timeout}), DW'(3'b000));
    runTxn(0, rand128(), 0, 0, "t5_after_rst_ic");
    runTxn(2, rand128(), 0, 0, "t5_after_rst_dc");

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      if (!ic_strobe && ($urandom_range(0, 1) == 1)) begin
        ic_addr   = randAddr();
        ic_strobe = 1'b1;
      end
      if (!dc_strobe && (($urandom_range(0, 1) == 1) || !ic_strobe)) begin
        dc_we     = 1'($urandom_range(0, 1));
        dc_addr   = randAddr();
        dc_wdata  = rand128();
        dc_strobe = 1'b1;
      end
      runTxn(int'($urandom_range(0, 5)), rand128(), 0, 0, "rnd");
    end
    for (int k = 0; k < 2; k++) begin
      if (ic_strobe || dc_strobe) runTxn(1, rand128(), 0, 0, "rnd_drain");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
